// File: rtl/irq_pending_controller_if.sv
// Bundle between SoC interrupt sources/core and the pending interrupt controller.
// The slave modport is the controller side; master is the core/SoC side.
interface irq_pending_controller_if #(
   parameter int N = 8
);
   localparam int IDW = $clog2(N);

   logic [N-1:0]   irq;
   logic [N-1:0]   edge_mode;
   logic [N-1:0]   mask;
   logic           irq_valid;
   logic [IDW-1:0] irq_id;
   logic           irq_ack;
   logic           eoi;
   logic           in_service;
   logic [N-1:0]   pending;

   modport slave (
      input  irq, edge_mode, mask, irq_ack, eoi,
      output irq_valid, irq_id, in_service, pending
   );

   modport master (
      output irq, edge_mode, mask, irq_ack, eoi,
      input  irq_valid, irq_id, in_service, pending
   );
endinterface

// File: rtl/irq_pending_controller.sv
// Interrupt controller: per-source pending latches (edge/level), masking,
// highest-index priority and an ack/eoi claim handshake with registered outputs.
module irq_pending_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   input  logic edge_mode,
   input  logic clr,
   output logic pend
);
   logic irq_q;

   // Set beats clear so a rise coinciding with the claim is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
         pend  <= 1'b0;
      end else begin
         irq_q <= irq;
         if (edge_mode) pend <= (irq & ~irq_q) | (pend & ~clr);
         else           pend <= irq;
      end
   end
endmodule

module irq_pending_controller #(
   parameter int N = 8
) (
   input logic                      clk,
   input logic                      rst_n,
   irq_pending_controller_if.slave  bus
);
   localparam int IDW = $clog2(N);

   typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   pend, clr, eligible;
   logic [IDW-1:0] winner, id_q, id_nxt;
   logic           claim, valid, svc;

   assign claim    = (state == ASSERT) && bus.irq_ack;
   assign eligible = pend & ~bus.mask;

   for (genvar i = 0; i < N; i++) begin : g_src
      assign clr[i] = claim && (id_q == IDW'(i));
      irq_pending_cell u_cell (
         .clk       (clk),
         .rst_n     (rst_n),
         .irq       (bus.irq[i]),
         .edge_mode (bus.edge_mode[i]),
         .clr       (clr[i]),
         .pend      (pend[i])
      );
   end

   // Later (higher) indices overwrite earlier ones: highest index wins.
   always_comb begin
      winner = '0;
      for (int i = 0; i < N; i++)
         if (eligible[i]) winner = IDW'(i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         id_q  <= '0;
      end else begin
         state <= state_nxt;
         id_q  <= id_nxt;
      end
   end

   // Ack takes precedence over an eligibility drop: the core already saw irq_valid.
   always_comb begin
      state_nxt = state;
      id_nxt    = id_q;
      case (state)
         IDLE:
            if (|eligible) begin
               state_nxt = ASSERT;
               id_nxt    = winner;
            end
         ASSERT:
            if (bus.irq_ack)      state_nxt = SERVICE;
            else if (~|eligible)  state_nxt = IDLE;
            else                  id_nxt    = winner;
         SERVICE:
            if (bus.eoi) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      valid = (state == ASSERT);
      svc   = (state == SERVICE);
   end

   assign bus.irq_valid  = valid;
   assign bus.in_service = svc;
   assign bus.irq_id     = id_q;
   assign bus.pending    = pend;
endmodule

// File: tb/tb_irq_pending_controller.sv
// Directed bench for irq_pending_controller (N=8); expected values are hand-derived.
module tb_irq_pending_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errs = 0;
   int   checks = 0;

   irq_pending_controller_if #(.N(8)) bus ();

   irq_pending_controller #(.N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, landing 1ns after the last one.
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.irq = '0; bus.mask = '0; bus.irq_ack = 1'b0; bus.eoi = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_reset();
      bus.irq = 8'hFF; bus.edge_mode = 8'h00; bus.mask = '0;
      bus.irq_ack = 1'b0; bus.eoi = 1'b0; rst_n = 1'b0;
      step(2);
      checks++; if ({bus.irq_valid, bus.in_service} !== 2'b00) begin errs++; $display("FAIL reset_flags got=%b exp=00", {bus.irq_valid, bus.in_service}); end
      checks++; if (bus.irq_id !== 3'd0) begin errs++; $display("FAIL reset_id got=%0d exp=0", bus.irq_id); end
      checks++; if (bus.pending !== 8'h00) begin errs++; $display("FAIL reset_pending got=%h exp=00", bus.pending); end
      rst_n = 1'b1;
      step(1);
      checks++; if (bus.pending !== 8'hFF || bus.irq_valid !== 1'b0) begin errs++; $display("FAIL reset_rel1 pending=%h valid=%b exp FF/0", bus.pending, bus.irq_valid); end
      step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd7) begin errs++; $display("FAIL reset_rel2 valid=%b id=%0d exp 1/7", bus.irq_valid, bus.irq_id); end
      do_reset();
   endtask

   task automatic test_edge_claim();
      bus.edge_mode = 8'hFF;
      bus.irq = 8'h08; step(1); bus.irq = '0;
      checks++; if (bus.pending !== 8'h08 || bus.irq_valid !== 1'b0) begin errs++; $display("FAIL edge_latch pending=%h valid=%b exp 08/0", bus.pending, bus.irq_valid); end
      step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd3) begin errs++; $display("FAIL edge_raise valid=%b id=%0d exp 1/3", bus.irq_valid, bus.irq_id); end
      bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
      checks++; if (bus.pending !== 8'h00 || bus.irq_valid !== 1'b0 || bus.in_service !== 1'b1) begin errs++; $display("FAIL edge_claim pending=%h valid=%b insvc=%b exp 00/0/1", bus.pending, bus.irq_valid, bus.in_service); end
      step(2);
      checks++; if (bus.in_service !== 1'b1) begin errs++; $display("FAIL edge_hold insvc=%b exp 1", bus.in_service); end
      bus.eoi = 1'b1; step(1); bus.eoi = 1'b0;
      checks++; if (bus.in_service !== 1'b0 || bus.irq_valid !== 1'b0) begin errs++; $display("FAIL edge_eoi insvc=%b valid=%b exp 0/0", bus.in_service, bus.irq_valid); end
      step(1);
      checks++; if (bus.irq_valid !== 1'b0) begin errs++; $display("FAIL edge_after_eoi valid=%b exp 0", bus.irq_valid); end
      do_reset();
   endtask

   task automatic test_priority();
      bus.edge_mode = 8'hFF;
      bus.irq = 8'h08; step(1); bus.irq = '0; step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd3) begin errs++; $display("FAIL prio_first valid=%b id=%0d exp 1/3", bus.irq_valid, bus.irq_id); end
      step(1);
      bus.irq = 8'h40; step(1); bus.irq = '0;
      checks++; if (bus.pending !== 8'h48 || bus.irq_id !== 3'd3) begin errs++; $display("FAIL prio_latch pending=%h id=%0d exp 48/3", bus.pending, bus.irq_id); end
      step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd6) begin errs++; $display("FAIL prio_preempt valid=%b id=%0d exp 1/6", bus.irq_valid, bus.irq_id); end
      bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
      checks++; if (bus.pending !== 8'h08 || bus.in_service !== 1'b1) begin errs++; $display("FAIL prio_claim pending=%h insvc=%b exp 08/1", bus.pending, bus.in_service); end
      bus.eoi = 1'b1; step(1); bus.eoi = 1'b0; step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd3) begin errs++; $display("FAIL prio_reraise valid=%b id=%0d exp 1/3", bus.irq_valid, bus.irq_id); end
      do_reset();
   endtask

   task automatic test_mask();
      bus.edge_mode = 8'hFF; bus.mask = 8'h40;
      bus.irq = 8'h40; step(1); bus.irq = '0; step(2);
      checks++; if (bus.pending !== 8'h40 || bus.irq_valid !== 1'b0) begin errs++; $display("FAIL mask_block pending=%h valid=%b exp 40/0", bus.pending, bus.irq_valid); end
      bus.mask = 8'h00; step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd6) begin errs++; $display("FAIL mask_release valid=%b id=%0d exp 1/6", bus.irq_valid, bus.irq_id); end
      bus.mask = 8'hFF; step(1);
      checks++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h40) begin errs++; $display("FAIL mask_all valid=%b pending=%h exp 0/40", bus.irq_valid, bus.pending); end
      do_reset();
   endtask

   task automatic test_level();
      bus.edge_mode = 8'h00;
      bus.irq = 8'h20; step(2);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd5) begin errs++; $display("FAIL level_raise valid=%b id=%0d exp 1/5", bus.irq_valid, bus.irq_id); end
      bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
      checks++; if (bus.pending !== 8'h20 || bus.in_service !== 1'b1) begin errs++; $display("FAIL level_claim pending=%h insvc=%b exp 20/1", bus.pending, bus.in_service); end
      bus.eoi = 1'b1; step(1); bus.eoi = 1'b0;
      checks++; if (bus.irq_valid !== 1'b0 || bus.in_service !== 1'b0) begin errs++; $display("FAIL level_eoi valid=%b insvc=%b exp 0/0", bus.irq_valid, bus.in_service); end
      step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd5) begin errs++; $display("FAIL level_reraise valid=%b id=%0d exp 1/5", bus.irq_valid, bus.irq_id); end
      bus.irq = '0; step(1);
      checks++; if (bus.pending !== 8'h00 || bus.irq_valid !== 1'b1) begin errs++; $display("FAIL level_drop1 pending=%h valid=%b exp 00/1", bus.pending, bus.irq_valid); end
      step(1);
      checks++; if (bus.irq_valid !== 1'b0) begin errs++; $display("FAIL level_drop2 valid=%b exp 0", bus.irq_valid); end
      do_reset();
   endtask

   task automatic test_collision_reset();
      bus.edge_mode = 8'hFF;
      bus.irq = 8'h04; step(1); bus.irq = '0; step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd2) begin errs++; $display("FAIL coll_raise valid=%b id=%0d exp 1/2", bus.irq_valid, bus.irq_id); end
      bus.irq = 8'h04; bus.irq_ack = 1'b1; step(1); bus.irq = '0; bus.irq_ack = 1'b0;
      checks++; if (bus.pending !== 8'h04 || bus.in_service !== 1'b1 || bus.irq_valid !== 1'b0) begin errs++; $display("FAIL coll_setwins pending=%h insvc=%b valid=%b exp 04/1/0", bus.pending, bus.in_service, bus.irq_valid); end
      rst_n = 1'b0; #1;
      checks++; if (bus.pending !== 8'h00 || bus.in_service !== 1'b0 || bus.irq_valid !== 1'b0 || bus.irq_id !== 3'd0) begin errs++; $display("FAIL async_reset pending=%h insvc=%b valid=%b id=%0d exp 00/0/0/0", bus.pending, bus.in_service, bus.irq_valid, bus.irq_id); end
      do_reset();
   endtask

   task automatic test_stray();
      bus.edge_mode = 8'hFF;
      bus.eoi = 1'b1; step(1); bus.eoi = 1'b0;
      checks++; if ({bus.irq_valid, bus.in_service} !== 2'b00 || bus.pending !== 8'h00) begin errs++; $display("FAIL stray_eoi flags=%b pending=%h exp 00/00", {bus.irq_valid, bus.in_service}, bus.pending); end
      bus.irq = 8'h02; step(1); bus.irq = '0; step(1);
      bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
      bus.irq = 8'h10; step(1); bus.irq = '0;
      bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
      checks++; if (bus.in_service !== 1'b1 || bus.irq_valid !== 1'b0 || bus.pending !== 8'h10) begin errs++; $display("FAIL stray_ack insvc=%b valid=%b pending=%h exp 1/0/10", bus.in_service, bus.irq_valid, bus.pending); end
      bus.eoi = 1'b1; step(1); bus.eoi = 1'b0; step(1);
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd4) begin errs++; $display("FAIL stray_resume valid=%b id=%0d exp 1/4", bus.irq_valid, bus.irq_id); end
      do_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_edge_claim();
      test_priority();
      test_mask();
      test_level();
      test_collision_reset();
      test_stray();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/irq_pending_controller.md
Name: irq_pending_controller

Overview:
- Clocked, parametrised interrupt controller with pending latches, per-source edge/level trigger mode, masking, fixed priority and a claim/complete (ack/eoi) handshake toward the CPU core.
- Sits between SoC peripheral interrupt lines and the processor interrupt input.
- Successor to the combinational priority encoder: adds latched edge capture, in-service tracking and a registered, stable request output.

Parameters:
- N, 8, number of interrupt sources; legal range 2..32.
- IDW, $clog2(N), width of irq_id; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irq  input  N  raw interrupt lines; already synchronous to clk.
- edge_mode  input  N  per source: 1 = rising-edge triggered, 0 = level triggered; quasi-static.
- mask  input  N  per source: 1 = blocked from arbitration.
- irq_valid  output  1  registered request to the core.
- irq_id  output  IDW  registered index of the requesting source; meaningful only while irq_valid=1.
- irq_ack  input  1  single-cycle claim pulse from the core.
- eoi  input  1  single-cycle end-of-interrupt pulse from the core.
- in_service  output  1  high while a claimed interrupt is being serviced.
- pending  output  N  registered pending vector, unmasked view, for status readback.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - irq_valid=0, irq_id=0, in_service=0, pending=0.
  - Internal irq_q=0, FSM=IDLE.
  - Asserting rst_n=0 mid-service aborts the service; no state survives reset.
- Edge detect:
  - irq_q <= irq every cycle.
  - A rise on source i is irq[i]=1 while irq_q[i]=0.
- Pending update, every cycle:
  - Edge source (edge_mode[i]=1): pending[i] sets on a rise and holds until cleared by a claim.
  - Edge set/clear collision: if a rise and a claim-clear of source i fall in the same cycle, set wins. No edge is lost.
  - Level source (edge_mode[i]=0): pending[i] <= irq[i]. The claim does not clear it.
  - Masking does not affect pending capture. A masked edge stays latched and is raised once unmasked.
- Arbitration:
  - eligible = pending & ~mask.
  - Highest index wins (fixed priority, matches predecessor).
- FSM states and transitions:
  - IDLE:
    - If eligible≠0, go to ASSERT with irq_valid<=1 and irq_id<=winner.
    - Otherwise irq_valid=0.
  - ASSERT:
    - irq_id re-evaluated each cycle; a higher-priority arrival replaces the id before the claim.
    - If eligible becomes 0 (level source dropped, or newly masked), go back to IDLE with irq_valid<=0.
    - On irq_ack=1, go to SERVICE. The claim uses the current registered irq_id: clear pending[irq_id] if that source is edge mode, set irq_valid<=0 and in_service<=1.
  - SERVICE:
    - irq_valid held 0; no nesting or preemption.
    - On eoi=1, go to IDLE with in_service<=0.
    - Arbitration resumes the next cycle. A still-asserted level source re-raises.
- Latency:
  - A rise or level assertion sampled at edge k sets pending after k.
  - irq_valid/irq_id update after edge k+1, i.e. 2 cycles.
- Ignored and undefined inputs:
  - irq_ack outside ASSERT is ignored.
  - eoi outside SERVICE is ignored.
  - irq_ack and eoi together in ASSERT: ack is taken, eoi is ignored.
- Stability: irq_id changes only on an edge; no combinational path from inputs to outputs.

Test Plan:
- Reset: rst_n=0 with irq=8'hFF, edge_mode=0 -> all outputs 0. Release; 2 cycles later -> irq_valid=1, irq_id=7.
- Edge latch and claim:
  - edge_mode=8'hFF, one-cycle pulse irq[3] -> pending=8'h08; irq_valid=1, irq_id=3 two cycles after the pulse.
  - irq_ack -> next cycle pending=0, irq_valid=0, in_service=1.
  - eoi -> in_service=0; irq_valid stays 0.
- Priority and preemption: edge pulse on 3; one cycle after irq_valid rises, pulse on 6 -> irq_id changes 3→6 (irq_valid stays 1). Ack claims 6; after eoi, irq_id=3 re-raised.
- Mask:
  - Edge pulse on 6 with mask=8'h40 -> pending=8'h40, irq_valid=0.
  - Clear mask -> irq_valid=1, irq_id=6 one cycle later.
  - mask=8'hFF with pending non-zero in ASSERT -> irq_valid returns to 0.
- Level semantics: edge_mode=0, irq[5] held high; ack, then eoi -> irq_valid re-asserts with id 5. Drop irq[5] while in ASSERT -> irq_valid=0 two cycles later.
- Collision, reset and ignored handshakes:
  - New rise on source 2 in the same cycle as ack of source 2 -> pending[2] stays 1.
  - rst_n pulsed low during SERVICE -> immediate all-zero outputs.
  - Stray eoi in IDLE and stray ack in SERVICE -> no state change.
